dsp_mac_sequencer: RTL and testbench

//  Control-only sequencer for the DSP48A1 slice; computes P = sum(A*B) over LEN operand beats.

---
 rtl/dsp_mac_sequencer.sv | 149 ++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: control FSM driving a DSP48A1 slice to form P = sum(A*B).
// Define DSP_SEQ_ABORT_EN to add the abort/aborted port pair.
module dsp_mac_sequencer #(
  parameter int CNT_W = 10,
  parameter int MREG  = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       OPMODE,
  output logic             CEA,
  output logic             CEB,
  output logic             CEM,
  output logic             CEP,
  output logic             RSTP,
  output logic             busy,
  output logic             done,
`ifdef DSP_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int VW = (MREG != 0) ? 2 : 1;
  localparam logic [7:0] OPM_MAC = 8'h09;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [VW-1:0]    r_vsr;
  logic [VW-1:0]    w_vsr_next;
  logic             w_beat;
  logic             w_last;
  logic             w_abort;
  logic             w_ready;
  logic [7:0]       w_opm;
  logic             w_rstp;
  logic             w_busy;
  logic             w_done;

  assign w_beat = in_valid && (r_state == S_RUN);
  assign w_last = w_beat && (r_cnt == r_len - 1'b1);

`ifdef DSP_SEQ_ABORT_EN
  logic r_aborted;
  assign w_abort = abort && (r_state == S_CLEAR ||
                             r_state == S_RUN ||
                             r_state == S_DRAIN);
  assign aborted = r_aborted;
`else
  assign w_abort = 1'b0;
`endif

  // One bit per pipeline stage between the A1/B1 capture and P.
  always_comb begin
    w_vsr_next    = r_vsr << 1;
    w_vsr_next[0] = w_beat;
  end

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    w_opm   = 8'h00;
    w_rstp  = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: begin
        w_rstp = 1'b1;
        w_busy = 1'b1;
        w_next = S_RUN;
      end
      S_RUN: begin
        w_ready = 1'b1;
        w_opm   = OPM_MAC;
        w_busy  = 1'b1;
        if (w_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_opm  = OPM_MAC;
        w_busy = 1'b1;
        if (w_vsr_next == '0) w_next = S_DONE;
      end
      S_DONE: begin
        w_opm  = OPM_MAC;
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_vsr   <= '0;
    end else begin
      r_state <= w_next;
      r_vsr   <= w_abort ? '0 : w_vsr_next;
      if (r_state == S_IDLE && start) begin
        r_len <= len;
        r_cnt <= '0;
      end else if (w_beat && !w_abort) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef DSP_SEQ_ABORT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_aborted <= 1'b0;
    else        r_aborted <= w_abort;
  end
`endif

  // The slice gates its P reset with CEP, so CLEAR raises both.
  assign in_ready = w_ready;
  assign OPMODE   = w_opm;
  assign CEA      = w_beat;
  assign CEB      = w_beat;
  assign CEM      = (MREG != 0) ? r_vsr[0] : 1'b0;
  assign CEP      = r_vsr[VW-1] | w_rstp;
  assign RSTP     = w_rstp;
  assign busy     = w_busy;
  assign done     = w_done;
  assign beat_cnt = r_cnt;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// tb_dsp_mac_sequencer: scoreboard bench with a behavioural DSP48A1 slice model.
// Exercises DSP_SEQ_ABORT_EN paths only when that macro is defined.
module tb_dsp_mac_sequencer;
  localparam int CNT_W = 10;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       OPMODE;
  logic             CEA, CEB, CEM, CEP, RSTP, busy, done;
  logic [CNT_W-1:0] beat_cnt;
`ifdef DSP_SEQ_ABORT_EN
  logic             abort = 1'b0;
  logic             aborted;
`endif

  logic [17:0] a_in = '0;
  logic [17:0] b_in = '0;

  dsp_mac_sequencer #(.CNT_W(CNT_W), .MREG(1)) u_dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .start    (start),
    .len      (len),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .OPMODE   (OPMODE),
    .CEA      (CEA),
    .CEB      (CEB),
    .CEM      (CEM),
    .CEP      (CEP),
    .RSTP     (RSTP),
    .busy     (busy),
    .done     (done),
`ifdef DSP_SEQ_ABORT_EN
    .abort    (abort),
    .aborted  (aborted),
`endif
    .beat_cnt (beat_cnt)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural slice: A1/B1 -> M -> P accumulator, CE-gated sync P reset.
  logic [17:0] a1 = '0;
  logic [17:0] b1 = '0;
  logic [35:0] m  = '0;
  logic [47:0] p  = '0;
  always @(posedge CLK) begin
    if (CEA) a1 <= a_in;
    if (CEB) b1 <= b_in;
    if (CEM) m <= a1 * b1;
    if (CEP) begin
      if (RSTP) p <= '0;
      else if (OPMODE == 8'h09) p <= p + {12'd0, m};
    end
  end

  wire [CNT_W+15:0] w_outs = {in_ready, OPMODE, CEA, CEB, CEM,
                              CEP, RSTP, busy, done, beat_cnt};

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [47:0] sum;
    int          blen;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  logic [47:0] last_sum = '0;

  always @(negedge CLK) begin
    if (RST_N && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("p_sum", p, e.sum);
        check("beat_cnt_done", beat_cnt, e.blen);
        check("done_cycle", cyc, e.cyc);
        check("opmode_done", OPMODE, 8'h09);
      end
    end
  end

  task automatic run_job(input int L, input int gap_at, input int gap_n,
                         input int restart_at);
    logic [17:0] av[$];
    logic [17:0] bv[$];
    logic [47:0] s;
    exp_t e;
    int t0, idx, gap_left, guard;
    bit gap_done;
    s = '0;
    for (int i = 0; i < L; i++) begin
      av.push_back(18'($urandom_range(0, 4095)));
      bv.push_back(18'($urandom_range(0, 4095)));
      s += av[i] * bv[i];
    end
    @(posedge CLK); #1;
    t0 = cyc;
    start = 1'b1;
    len = CNT_W'(L);
    e.sum  = (L == 0) ? last_sum : s;
    e.blen = L;
    e.cyc  = (L == 0) ? t0 + 1 : t0 + 2 + (L - 1) + gap_n + 3;
    sb.push_back(e);
    if (L != 0) last_sum = s;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("rstp_clear", RSTP, L != 0);
    check("busy_clear", busy, L != 0);
    idx = 0; gap_left = 0; guard = 0; gap_done = 0;
    while (idx < L && guard < 200) begin
      @(posedge CLK); #1;
      guard++;
      start = 1'b0;
      if (idx == restart_at) begin
        start = 1'b1;
        len = CNT_W'(L + 3);
      end
      if (gap_n > 0 && idx == gap_at && !gap_done) begin
        gap_left = gap_n;
        gap_done = 1;
      end
      if (gap_left > 0) begin
        in_valid = 1'b0;
        gap_left--;
      end else begin
        in_valid = 1'b1;
        a_in = av[idx];
        b_in = bv[idx];
      end
      @(negedge CLK);
      if (in_valid && in_ready) idx++;
    end
    @(posedge CLK); #1;
    in_valid = 1'b0;
    start = 1'b0;
    if (idx != L) check("beats_accepted", idx, L);
    guard = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(posedge CLK);
      guard++;
    end
    check("job_completed", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int rl;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_outputs", w_outs, '0);
    check("rst_beat_cnt", beat_cnt, '0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    @(negedge CLK);
    check("idle_outputs", w_outs, '0);

    run_job(4, -1, 0, -1);
    run_job(4, 2, 2, -1);
    run_job(1, -1, 0, -1);
    run_job(0, -1, 0, -1);
    run_job(6, -1, 0, 2);
    for (int k = 0; k < 4; k++) begin
      rl = $urandom_range(1, 9);
      run_job(rl, $urandom_range(0, rl - 1), $urandom_range(0, 3), -1);
    end

    // Asynchronous reset in the middle of RUN.
    @(posedge CLK); #1;
    start = 1'b1; len = CNT_W'(4);
    @(posedge CLK); #1;
    start = 1'b0;
    @(posedge CLK); #1;
    in_valid = 1'b1; a_in = 18'd7; b_in = 18'd9;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    check("cnt_before_rst", beat_cnt, 2);
    #1 RST_N = 1'b0;
    #1;
    check("async_rst_outputs", w_outs, '0);
    check("async_rst_cnt", beat_cnt, '0);
    in_valid = 1'b0;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    run_job(4, -1, 0, -1);

`ifdef DSP_SEQ_ABORT_EN
    @(posedge CLK); #1;
    start = 1'b1; len = CNT_W'(8);
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      in_valid = 1'b1;
    end
    @(posedge CLK); #1;
    abort = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    check("aborted_pulse", aborted, 1'b1);
    check("abort_ce", {CEA, CEB, CEM, CEP}, 4'b0);
    check("abort_idle", {busy, in_ready, done}, 3'b0);
    @(negedge CLK);
    check("aborted_single", aborted, 1'b0);
    run_job(5, -1, 0, -1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
